// File: rtl/uart_baud_gen.sv
// UART baud-rate generator: fractional phase accumulator producing a 16x
// oversampling strobe, divided by 16 to give the bit-rate tick.
module uart_baud_gen #(
  parameter int CLOCK_FREQ = 50000000,
  parameter int BAUD_RATE  = 115200
) (
  input  logic clk,
  input  logic rst,
  output logic baud_tick,
  output logic baud_tick_16x
);

  // One spare bit above what acc + INC can reach, so the sum never wraps.
  localparam int ACC_W = $clog2(CLOCK_FREQ + 16 * BAUD_RATE) + 1;
  localparam logic [ACC_W-1:0] INC = ACC_W'(16 * BAUD_RATE);
  localparam logic [ACC_W-1:0] MOD = ACC_W'(CLOCK_FREQ);

  generate
    if (CLOCK_FREQ <= 0 || BAUD_RATE <= 0 || 16 * BAUD_RATE > CLOCK_FREQ) begin : g_bad_params
      $error("uart_baud_gen: need CLOCK_FREQ > 0, BAUD_RATE > 0 and 16*BAUD_RATE <= CLOCK_FREQ");
    end
  endgenerate

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_sum;
  logic             wrap;
  logic [3:0]       sub_cnt;

  always_comb begin
    acc_sum = acc + INC;
    wrap    = (acc_sum >= MOD);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      acc           <= '0;
      sub_cnt       <= '0;
      baud_tick     <= 1'b0;
      baud_tick_16x <= 1'b0;
    end else begin
      baud_tick_16x <= wrap;
      // The bit tick lands on the 16th strobe of each group.
      baud_tick     <= wrap && (sub_cnt == 4'd15);
      if (wrap) begin
        acc     <= acc_sum - MOD;
        sub_cnt <= sub_cnt + 4'd1;
      end else begin
        acc     <= acc_sum;
      end
    end
  end

endmodule

// File: tb/tb_uart_baud_gen.sv
// Self-checking bench for uart_baud_gen: three parameter sets run side by side
// against a closed-form pulse-count model, with randomized reset disturbances.
module tb_uart_baud_gen;

  localparam int NI = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_v [NI];
  logic t16   [NI];
  logic tb1   [NI];

  uart_baud_gen #(.CLOCK_FREQ(1000000), .BAUD_RATE(9600)) u_a (
    .clk(clk), .rst(rst_v[0]), .baud_tick(tb1[0]), .baud_tick_16x(t16[0]));
  uart_baud_gen #(.CLOCK_FREQ(1600000), .BAUD_RATE(10000)) u_b (
    .clk(clk), .rst(rst_v[1]), .baud_tick(tb1[1]), .baud_tick_16x(t16[1]));
  uart_baud_gen u_c (
    .clk(clk), .rst(rst_v[2]), .baud_tick(tb1[2]), .baud_tick_16x(t16[2]));

  longint inc  [NI] = '{153600, 160000, 1843200};
  longint modv [NI] = '{1000000, 1600000, 50000000};

  longint k      [NI];
  longint cnt16  [NI];
  longint cntb   [NI];
  longint last16 [NI];
  longint lastb  [NI];
  bit     seen16 [NI];
  bit     seenb  [NI];

  int total = 0;
  int bad   = 0;

  // Number of 16x pulses expected after n enabled clocks since release.
  function automatic longint pc(int i, longint n);
    return (n * inc[i]) / modv[i];
  endfunction

  function automatic longint cdiv(longint a, longint b);
    return (a + b - 1) / b;
  endfunction

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one clock and compare every instance against the model.
  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      bit     e16;
      bit     eb;
      longint iv;
      if (!rst_v[i]) begin
        k[i] = 0; cnt16[i] = 0; cntb[i] = 0; last16[i] = 0; lastb[i] = 0;
        seen16[i] = 0; seenb[i] = 0;
        e16 = 0; eb = 0;
      end else begin
        k[i]++;
        e16 = (pc(i, k[i]) != pc(i, k[i] - 1));
        eb  = e16 && (pc(i, k[i]) % 16 == 0);
      end
      check($sformatf("tick16_%0d_k%0d", i, k[i]), {63'd0, t16[i]}, {63'd0, e16});
      check($sformatf("tick_%0d_k%0d", i, k[i]), {63'd0, tb1[i]}, {63'd0, eb});
      if (t16[i] === 1'b1 && rst_v[i]) begin
        iv = k[i] - last16[i];
        if (!seen16[i])
          check($sformatf("first16_%0d", i), k[i], cdiv(modv[i], inc[i]));
        else
          check($sformatf("int16_%0d_iv%0d", i, iv),
                {63'd0, (iv >= modv[i] / inc[i] && iv <= cdiv(modv[i], inc[i]))}, 64'd1);
        seen16[i] = 1; last16[i] = k[i]; cnt16[i]++;
      end
      if (tb1[i] === 1'b1 && rst_v[i]) begin
        iv = k[i] - lastb[i];
        check($sformatf("coinc_%0d", i), {63'd0, t16[i]}, 64'd1);
        if (!seenb[i])
          check($sformatf("first_tick_%0d", i), k[i], cdiv(16 * modv[i], inc[i]));
        else
          check($sformatf("int_tick_%0d_iv%0d", i, iv),
                {63'd0, (iv >= (16 * modv[i]) / inc[i] && iv <= cdiv(16 * modv[i], inc[i]))}, 64'd1);
        seenb[i] = 1; lastb[i] = k[i]; cntb[i]++;
      end
    end
  endtask

  initial begin
    int     guard;
    longint target;

    for (int i = 0; i < NI; i++) begin
      rst_v[i] = 1'b0;
      k[i] = 0; cnt16[i] = 0; cntb[i] = 0; last16[i] = 0; lastb[i] = 0;
      seen16[i] = 0; seenb[i] = 0;
    end

    // Reset state
    repeat (3) step();
    check("acc_reset", 64'(u_a.acc), 64'd0);

    // Release and run 625 enabled clocks on the 1 MHz / 9600 instance
    for (int i = 0; i < NI; i++) rst_v[i] = 1'b1;
    repeat (625) step();
    check("cnt16_625", cnt16[0], pc(0, 625));
    check("cntb_625", cntb[0], pc(0, 625) / 16);
    check("acc_625", 64'(u_a.acc), (625 * inc[0]) % modv[0]);

    // At least ten more baud intervals, checked inline
    guard = 0;
    while (cntb[0] < 17 && guard < 2000) begin step(); guard++; end
    check("ten_intervals", {63'd0, (cntb[0] >= 17)}, 64'd1);

    // Reset for 3 clocks at a random point between baud ticks
    target = 30 + longint'($urandom_range(0, 40));
    guard = 0;
    while ((k[0] - lastb[0]) != target && guard < 300) begin step(); guard++; end
    check("mid_point_reached", k[0] - lastb[0], target);
    rst_v[0] = 1'b0;
    repeat (3) step();
    rst_v[0] = 1'b1;
    guard = 0;
    while (!seenb[0] && guard < 300) begin step(); guard++; end
    check("tick_after_release", lastb[0], 64'd105);

    // Random-length resets at random points, including on tick cycles
    repeat (4) begin
      repeat ($urandom_range(1, 300)) step();
      rst_v[0] = 1'b0;
      repeat ($urandom_range(1, 4)) step();
      rst_v[0] = 1'b1;
    end

    // Long run for the default-parameter instance
    guard = 0;
    while (k[2] < 15625 && guard < 20000) begin step(); guard++; end
    check("k_c_reached", k[2], 64'd15625);
    check("cnt16_c", cnt16[2], pc(2, 15625));
    check("cntb_c", cntb[2], pc(2, 15625) / 16);
    check("cnt16_b", cnt16[1], pc(1, k[1]));
    check("cntb_b", cntb[1], pc(1, k[1]) / 16);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_baud_gen.md
UART_BAUD_GEN -- requirements
Module: uart_baud_gen

Interface
REQ-001 Parameter CLOCK_FREQ, default 50000000, input clock frequency in Hz (positive integer).
REQ-002 Parameter BAUD_RATE, default 115200, serial bit rate in bits/s (positive integer).
REQ-003 clk  input  1  single clock, all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low (rst==0 sampled at a rising clk edge resets the block).
REQ-005 baud_tick  output  1  one-clk pulse at the bit rate (BAUD_RATE).
REQ-006 baud_tick_16x  output  1  one-clk pulse at 16x the bit rate (oversampling strobe).

Function
REQ-007 The 16x strobe SHALL use a fractional phase accumulator, not an integer divider: INC = 16*BAUD_RATE, MOD = CLOCK_FREQ.
REQ-008 Each clk with rst==1: next = acc + INC; if next >= MOD then acc <= next - MOD and baud_tick_16x <= 1, else acc <= next and baud_tick_16x <= 0.
REQ-009 Accumulator width SHALL be $clog2(CLOCK_FREQ + 16*BAUD_RATE) + 1 bits; the sum SHALL never overflow; acc SHALL always remain in [0, MOD-1].
REQ-010 Long-term 16x rate SHALL be exact: after N enabled clocks, count of baud_tick_16x pulses = floor(N*INC/MOD).
REQ-011 A 4-bit sub-counter SHALL increment on every baud_tick_16x pulse, wrapping 15 -> 0.
REQ-012 baud_tick SHALL be 1 for exactly the clk in which the 16th baud_tick_16x pulse of each group occurs (sub-counter == 15 and 16x tick firing); baud_tick SHALL always coincide with a baud_tick_16x pulse.
REQ-013 Both outputs SHALL be registered, high for exactly one clk per event, never high on consecutive clks unless INC >= MOD/2 (baud_tick_16x only).
REQ-014 Period of baud_tick_16x SHALL be floor(MOD/INC) or ceil(MOD/INC) clks; period of baud_tick floor or ceil of 16*MOD/INC clks.
REQ-015 Elaboration SHALL fail (e.g., $error in a generate check) if 16*BAUD_RATE > CLOCK_FREQ or either parameter is 0.

Reset
REQ-016 While rst==0 at a clk edge: acc <= 0, sub-counter <= 0, baud_tick <= 0, baud_tick_16x <= 0.
REQ-017 Reset asserted mid-operation SHALL clear state on the next edge and suppress any tick that would have fired in that clk; counting restarts from phase 0 after release.
REQ-018 First baud_tick_16x after release SHALL occur in the ceil(MOD/INC)-th enabled clk; first baud_tick in the ceil(16*MOD/INC)-th enabled clk.

Verification
REQ-019 CLOCK_FREQ=1000000, BAUD_RATE=9600 (INC=153600), release reset -> first baud_tick_16x on 7th enabled clk, first baud_tick on 105th enabled clk.
REQ-020 Same parameters, run 625 enabled clks from reset -> exactly 96 baud_tick_16x and 6 baud_tick pulses; acc == 0 after clk 625.
REQ-021 Same parameters, capture 10 consecutive baud_tick edges -> every interval 104 or 105 clks, every 16x interval 6 or 7 clks, each baud_tick coincident with a 16x pulse.
REQ-022 Assert rst=0 for 3 clks midway between baud ticks -> outputs 0 during reset, next baud_tick exactly 105 clks after release.
REQ-023 CLOCK_FREQ=1600000, BAUD_RATE=10000 (integer ratio 10) -> baud_tick_16x strictly every 10 clks, baud_tick strictly every 160 clks.
REQ-024 Defaults (50 MHz, 115200) -> 16x interval 27 or 28 clks; over 15625 clks exactly 576 baud_tick_16x and 36 baud_tick pulses.
